// File: rtl/tick_sched_pkg.sv
// Shared defaults, per-channel reset taps and the configuration FSM state type
// for the tick scheduler.
package tick_sched_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 26;
  localparam int TAP_W_DEF  = 5;

  localparam int DEF_TAP [0:3] = '{16, 17, 18, 19};

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cfg_state_e;

  // Reset tap for a channel; never beyond the top counter bit for narrow counters.
  function automatic int def_tap(input int ch, input int cnt_w);
    int t;
    if (ch < 4) begin
      t = DEF_TAP[ch];
    end else begin
      t = cnt_w - 1;
    end
    if (t > cnt_w - 1) begin
      t = cnt_w - 1;
    end
    return t;
  endfunction

endpackage

// File: rtl/tick_sched_tap.sv
// One tick channel: tap/enable registers, boundary compare against the shared
// counter and the registered one-cycle strobe.
module tick_tap
  import tick_sched_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TAP_W   = TAP_W_DEF,
  parameter int RST_TAP = CNT_W_DEF - 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clr,
  input  logic [CNT_W-1:0] cnt,
  input  logic             load,
  input  logic [TAP_W-1:0] load_tap,
  input  logic             load_en,
  output logic             boundary,
  output logic             enabled,
  output logic             tick
);

  localparam logic [TAP_W-1:0] RST_TAP_L = TAP_W'(RST_TAP);
  localparam logic [CNT_W-1:0] ONE_L     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [TAP_W-1:0] tap_r;
  logic             en_r;
  logic             tick_r;
  logic [CNT_W-1:0] hit_s;
  logic [CNT_W-1:0] mask_s;

  // Boundary: low tap+1 counter bits equal exactly 1 << tap.
  always_comb begin
    hit_s    = ONE_L << tap_r;
    mask_s   = (hit_s << 1) - ONE_L;
    boundary = ((cnt & mask_s) == hit_s);
  end

  // A load that disables the channel also swallows its boundary tick.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tap_r  <= RST_TAP_L;
      en_r   <= 1'b1;
      tick_r <= 1'b0;
    end else begin
      tick_r <= !clr && en_r && boundary && !(load && !load_en);
      if (load) begin
        tap_r <= load_tap;
        en_r  <= load_en;
      end
    end
  end

  assign enabled = en_r;
  assign tick    = tick_r;

endmodule

// File: rtl/tick_sched.sv
// Multi-channel power-of-two tick generator with handshaked per-channel retune.
// Define TICK_SCHED_SYNC_EN to add the sync_req counter realign input.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TAP_W  = TAP_W_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [TAP_W-1:0]          cfg_tap,
  input  logic                      cfg_en,
`ifdef TICK_SCHED_SYNC_EN
  input  logic                      sync_req,
`endif
  output logic [NUM_CH-1:0]         tick_out
);

  localparam int               CH_W      = $clog2(NUM_CH);
  localparam logic [31:0]      CNT_W_U   = 32'(CNT_W);
  localparam logic [TAP_W-1:0] TAP_MAX_L = TAP_W'(CNT_W - 1);
  localparam logic [CNT_W-1:0] ONE_L     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]  cnt_r;
  cfg_state_e        state_r;
  logic              cfg_ready_r;
  logic [CH_W-1:0]   pend_ch_r;
  logic [TAP_W-1:0]  pend_tap_r;
  logic              pend_en_r;
  logic              sync_s;
  logic              apply_s;
  logic [TAP_W-1:0]  tap_clamp_s;
  logic [NUM_CH-1:0] boundary_s;
  logic [NUM_CH-1:0] enabled_s;
  logic [NUM_CH-1:0] load_s;

`ifdef TICK_SCHED_SYNC_EN
  assign sync_s = sync_req;
`else
  assign sync_s = 1'b0;
`endif

  // Out-of-range taps saturate at the top counter bit.
  always_comb begin
    if (32'(cfg_tap) >= CNT_W_U) begin
      tap_clamp_s = TAP_MAX_L;
    end else begin
      tap_clamp_s = cfg_tap;
    end
  end

  // A disabled target has no boundary to wait for; sync counts as a boundary.
  always_comb begin
    apply_s = (state_r == PEND) &&
              (sync_s || !enabled_s[pend_ch_r] || boundary_s[pend_ch_r]);
  end

  // Free-running divider counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_r <= '0;
    end else if (sync_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + ONE_L;
    end
  end

  // Configuration FSM.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r     <= IDLE;
      cfg_ready_r <= 1'b1;
      pend_ch_r   <= '0;
      pend_tap_r  <= '0;
      pend_en_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cfg_valid) begin
            pend_ch_r   <= cfg_ch;
            pend_tap_r  <= tap_clamp_s;
            pend_en_r   <= cfg_en;
            state_r     <= PEND;
            cfg_ready_r <= 1'b0;
          end
        end
        PEND: begin
          if (apply_s) begin
            state_r     <= IDLE;
            cfg_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          cfg_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign load_s[g] = apply_s && (pend_ch_r == CH_W'(g));

    tick_tap #(
      .CNT_W  (CNT_W),
      .TAP_W  (TAP_W),
      .RST_TAP(def_tap(g, CNT_W))
    ) u_tap (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .clr     (sync_s),
      .cnt     (cnt_r),
      .load    (load_s[g]),
      .load_tap(pend_tap_r),
      .load_en (pend_en_r),
      .boundary(boundary_s[g]),
      .enabled (enabled_s[g]),
      .tick    (tick_out[g])
    );
  end

endmodule

// File: tb/tb_tick_sched.sv
// Scoreboard bench for tick_sched: a narrow (CNT_W=8) instance for retune,
// clamp, wrap and sync behaviour, and a default instance for the reset tick.
module tb_tick_sched;

  logic       clk = 1'b0;
  logic       rst_s;
  logic       rst_d;
  logic       cfg_valid;
  logic [1:0] cfg_ch;
  logic [4:0] cfg_tap;
  logic       cfg_en;
  logic       cfg_ready;
  logic [3:0] tick_s;
  logic       cfg_ready_d;
  logic [3:0] tick_d;
`ifdef TICK_SCHED_SYNC_EN
  logic       sync_req;
`endif

  int cyc   = 0;
  int cyc_d = 0;
  int n_cmp = 0;
  int n_err = 0;
  int exp_q [4][$];
  bit seen_d = 1'b0;

  always #5 clk = ~clk;

  tick_sched #(.NUM_CH(4), .CNT_W(8), .TAP_W(5)) dut (
    .clk_in   (clk),
    .rst_in   (rst_s),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_tap  (cfg_tap),
    .cfg_en   (cfg_en),
`ifdef TICK_SCHED_SYNC_EN
    .sync_req (sync_req),
`endif
    .tick_out (tick_s)
  );

  tick_sched dut_dflt (
    .clk_in   (clk),
    .rst_in   (rst_d),
    .cfg_valid(1'b0),
    .cfg_ready(cfg_ready_d),
    .cfg_ch   (2'b00),
    .cfg_tap  (5'd0),
    .cfg_en   (1'b0),
`ifdef TICK_SCHED_SYNC_EN
    .sync_req (1'b0),
`endif
    .tick_out (tick_d)
  );

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic push_run(input int ch, input int first, input int step, input int limit);
    for (int t = first; t < limit; t += step) exp_q[ch].push_back(t);
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [4:0] tap, input logic en, input string nm);
    chk({nm, " ready before"}, int'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_tap   = tap;
    cfg_en    = en;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  function automatic int leftover();
    int n = 0;
    for (int c = 0; c < 4; c++) n += exp_q[c].size();
    return n;
  endfunction

  // Cycles since reset release; equals the narrow DUT counter until a sync.
  always @(posedge clk) begin
    if (rst_s) cyc <= 0;
    else       cyc <= cyc + 1;
    if (rst_d) cyc_d <= 0;
    else       cyc_d <= cyc_d + 1;
  end

  // Monitor: every tick pops its expected cycle; overdue entries are missed ticks.
  always @(negedge clk) begin
    int e;
    if (!rst_s) begin
      for (int c = 0; c < 4; c++) begin
        if (tick_s[c]) begin
          if (exp_q[c].size() == 0) begin
            chk($sformatf("unexpected tick ch%0d at cycle", c), cyc, -1);
          end else begin
            e = exp_q[c].pop_front();
            chk($sformatf("tick ch%0d cycle", c), cyc, e);
          end
        end else if (exp_q[c].size() > 0 && exp_q[c][0] < cyc) begin
          e = exp_q[c].pop_front();
          chk($sformatf("missing tick ch%0d cycle", c), cyc, e);
        end
      end
    end
    if (!rst_d && tick_d != 4'b0000 && !seen_d) begin
      seen_d = 1'b1;
      chk("dflt first tick cycle", cyc_d, 65537);
      chk("dflt first tick bits", int'(tick_d), 1);
    end
  end

  initial begin
    rst_s     = 1'b1;
    rst_d     = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = 2'b00;
    cfg_tap   = 5'd0;
    cfg_en    = 1'b0;
`ifdef TICK_SCHED_SYNC_EN
    sync_req  = 1'b0;
`endif
    repeat (3) begin
      @(negedge clk);
      chk("reset tick", int'(tick_s), 0);
      chk("reset ready", int'(cfg_ready), 1);
      chk("dflt reset tick", int'(tick_d), 0);
      chk("dflt reset ready", int'(cfg_ready_d), 1);
    end

    // Expected ticks of the narrow DUT for the whole first run.
    for (int c = 0; c < 4; c++) exp_q[c].push_back(129);
`ifdef TICK_SCHED_SYNC_EN
    push_run(0, 385, 256, 642);
    push_run(0, 734, 4, 1505);
    push_run(1, 385, 256, 645);
    push_run(1, 645, 8, 710);
    push_run(1, 860, 256, 1505);
    push_run(2, 137, 16, 731);
    push_run(2, 740, 16, 1505);
`else
    push_run(0, 385, 256, 1505);
    push_run(1, 385, 256, 645);
    push_run(1, 645, 8, 710);
    push_run(1, 897, 256, 1505);
    push_run(2, 137, 16, 1505);
`endif
    push_run(3, 394, 2, 401);

    rst_s = 1'b0;
    rst_d = 1'b0;

    goto(10);  cfg(2'd2, 5'd3, 1'b1, "c1");
    chk("c1 ready pend", int'(cfg_ready), 0);
    goto(128); chk("c1 ready before boundary", int'(cfg_ready), 0);
    goto(129); chk("c1 ready after boundary", int'(cfg_ready), 1);

    goto(130); cfg(2'd3, 5'd0, 1'b0, "c2");
    goto(384); chk("c2 ready before boundary", int'(cfg_ready), 0);
    goto(385); chk("c2 ready after boundary", int'(cfg_ready), 1);

    goto(390); cfg(2'd3, 5'd0, 1'b1, "c3");
    chk("c3 ready pend", int'(cfg_ready), 0);
    goto(392); chk("c3 ready applied", int'(cfg_ready), 1);

    goto(400); cfg(2'd3, 5'd0, 1'b0, "c4");
    chk("c4 ready pend", int'(cfg_ready), 0);
    goto(402); chk("c4 ready applied", int'(cfg_ready), 1);

    // Requests raised during PEND must be ignored.
    goto(410); cfg(2'd1, 5'd2, 1'b1, "c5");
    goto(420);
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_tap   = 5'd5;
    cfg_en    = 1'b0;
    goto(425); chk("c5 ready held low", int'(cfg_ready), 0);
    cfg_valid = 1'b0;
    goto(640); chk("c5 ready before boundary", int'(cfg_ready), 0);
    goto(641); chk("c5 ready after boundary", int'(cfg_ready), 1);

    goto(700); cfg(2'd1, 5'd31, 1'b1, "c6");
    goto(708); chk("c6 ready before boundary", int'(cfg_ready), 0);
    goto(709); chk("c6 ready after boundary", int'(cfg_ready), 1);

`ifdef TICK_SCHED_SYNC_EN
    goto(720); cfg(2'd0, 5'd1, 1'b1, "c7");
    goto(730);
    chk("c7 ready before sync", int'(cfg_ready), 0);
    sync_req = 1'b1;
    @(negedge clk);
    sync_req = 1'b0;
    chk("c7 ready after sync", int'(cfg_ready), 1);
    chk("c7 no tick on sync", int'(tick_s), 0);
`endif

    // A pending request is dropped by reset; defaults come back.
    goto(1500); cfg(2'd1, 5'd7, 1'b0, "c8");
    goto(1505);
    rst_s = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("re-reset tick", int'(tick_s), 0);
      chk("re-reset ready", int'(cfg_ready), 1);
    end
    chk("first run leftover ticks", leftover(), 0);
    for (int c = 0; c < 4; c++) exp_q[c].push_back(129);
    rst_s = 1'b0;
    goto(140);
    chk("second run ready", int'(cfg_ready), 1);
    rst_s = 1'b1;
    @(negedge clk);
    chk("second run leftover ticks", leftover(), 0);

    while (cyc_d < 65545) @(negedge clk);
    chk("dflt first tick seen", int'(seen_d), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
